ipsxb_fft_result_chk: RTL and testbench
=======================================

Name: ipsxb_fft_result_chk

Overview:
Downstream checker for the FFT demo. Consumes the FFT IP result stream produced from the frame generator's alternating FFT/IFFT test frames. Checks frame length and per-frame output signatures: frame k must match frame k-2, since the input and mode are identical. Returns the pulse that ends the generator's test run, plus pass/fail status.

Parameters:
LOGS_FFT_LEN, 4, log2 of transform length N (N = 2**LOGS_FFT_LEN)
OUTPUT_WIDTH, 21, significant bits per real/imag output sample
TEST_FRAME_NUM, 10, frames to check per test (>= 3)
TIMEOUT_CYC, 4096, enabled cycles in RUN with no accepted beat before timeout
DATAOUT_WIDTH, derived, OUTPUT_WIDTH rounded up to a multiple of 8

Ports:
i_aclk  input  1  clock
i_areset  input  1  asynchronous reset, active-high
i_aclken  input  1  clock enable; all state advances only when high
i_start_test  input  1  pulse; (re)starts a check run
i_axi4s_data_tvalid  input  1  FFT result beat valid (no backpressure; checker always accepts)
i_axi4s_data_tdata  input  DATAOUT_WIDTH*2  {imag, real}, each sign-extended
i_axi4s_data_tlast  input  1  last beat of result frame
o_chk_finished  output  1  one-enabled-cycle pulse when the run ends
o_test_pass  output  1  valid in DONE: 1 = no error flag set
o_err_len  output  1  sticky: tlast position wrong
o_err_sig  output  1  sticky: signature mismatch
o_err_timeout  output  1  sticky: stream stalled
o_frm_cnt  output  clog2(TEST_FRAME_NUM+1)  frames completed this run

Behaviour:
- Reset values: every output is 0; FSM is IDLE; signature history is 0.
- FSM states are IDLE, RUN and DONE, and change only on enabled cycles. i_start_test from any state clears counters, errors, history and the running signature, then enters RUN.
- i_start_test wins over a simultaneous beat; that beat is dropped.
- Beat accept = RUN & i_aclken & tvalid. In IDLE or DONE, beats are ignored.
- beat_cnt (LOGS_FFT_LEN bits) increments per accepted beat and returns to 0 on tlast.
- Length error:
  - tlast with beat_cnt != N-1 sets o_err_len; the frame still completes.
  - beat_cnt == N-1 without tlast sets o_err_len; beat_cnt wraps to 0 and no frame is counted.
- Signature (32 bit):
  - fold = XOR of tdata split into 32-bit chunks, top chunk zero-padded.
  - Update per beat: sig_next = {sig[30:0], sig[31]} ^ fold.
  - The first beat of a frame starts from sig = 0.
- Frame completion, on the tlast beat (1 cycle latency to flags and counters):
  - Final signature = sig_next.
  - If o_frm_cnt >= 2, compare the final signature with hist1; a mismatch sets o_err_sig.
  - Shift history: hist1 <= hist0, hist0 <= final.
  - o_frm_cnt increments.
- Run end:
  - When o_frm_cnt reaches TEST_FRAME_NUM, go to DONE, pulse o_chk_finished, and set o_test_pass = ~(any error).
- Timeout:
  - idle_cnt counts enabled RUN cycles without an accepted beat and clears on every accepted beat.
  - At TIMEOUT_CYC, set o_err_timeout, go to DONE, pulse o_chk_finished with o_test_pass = 0.
- DONE holds all flags until i_start_test or reset.
- o_chk_finished is high for exactly one enabled cycle; it stays high across intervening disabled cycles so the generator, which samples on its own enable, sees it.
- Reset asserted mid-frame returns every output to 0 immediately, asynchronously. A partial frame is discarded.
- While i_aclken is low, all registers hold.

Test Plan:
1. Nominal run:
   - Stimulus: i_aclken = 1, start pulse, 10 well-formed frames of 16 beats; frames with the same parity are identical (even frames carry constant data 0x000001_000002).
   - Response: o_frm_cnt = 10, one o_chk_finished pulse, o_test_pass = 1, all errors 0.
2. Short frame:
   - Stimulus: frame 3 has tlast on beat 14 (beat_cnt = 13).
   - Response: o_err_len = 1, frame still counted, o_test_pass = 0 at DONE.
3. Missing tlast:
   - Stimulus: frame 2 sends 16 beats without tlast, then normal frames.
   - Response: o_err_len = 1; o_frm_cnt lags by 1, so a total of 11 frames is needed to finish.
4. Corruption:
   - Stimulus: flip tdata bit 0 on beat 5 of frame 4.
   - Response: o_err_sig = 1 after frame 4's tlast; frame 6 also mismatches, since frame 4 is in history; o_test_pass = 0.
5. Stall:
   - Stimulus: stop tvalid after 4 frames.
   - Response: after exactly 4096 enabled cycles, o_err_timeout = 1 and o_chk_finished pulses.
6. Clock enable, restart and reset:
   - Stimulus: run scenario 1 with i_aclken toggling 1/0.
   - Response: identical results.
   - Stimulus: start pulse mid-run.
   - Response: counters clear, and a fresh 10-frame run passes.
   - Stimulus: i_areset mid-frame.
   - Response: all outputs 0 the same cycle.

Source files
------------

// File: rtl/ipsxb_fft_result_chk.sv
// Result-stream checker for the FFT demo: validates frame length and compares each
// frame's 32-bit signature with the frame two positions earlier (same input and mode).
module ipsxb_fft_result_chk #(
    parameter int LOGS_FFT_LEN   = 4,
    parameter int OUTPUT_WIDTH   = 21,
    parameter int TEST_FRAME_NUM = 10,
    parameter int TIMEOUT_CYC    = 4096,
    localparam int DATAOUT_WIDTH = ((OUTPUT_WIDTH + 7) / 8) * 8,
    localparam int FRM_W         = $clog2(TEST_FRAME_NUM + 1)
) (
    input  logic                       i_aclk,
    input  logic                       i_areset,
    input  logic                       i_aclken,
    input  logic                       i_start_test,
    input  logic                       i_axi4s_data_tvalid,
    input  logic [DATAOUT_WIDTH*2-1:0] i_axi4s_data_tdata,
    input  logic                       i_axi4s_data_tlast,
    output logic                       o_chk_finished,
    output logic                       o_test_pass,
    output logic                       o_err_len,
    output logic                       o_err_sig,
    output logic                       o_err_timeout,
    output logic [FRM_W-1:0]           o_frm_cnt
);

    localparam int TD_W   = DATAOUT_WIDTH * 2;
    localparam int CHUNKS = (TD_W + 31) / 32;
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // XOR of the beat split into 32-bit chunks, top chunk zero-padded.
    function automatic logic [31:0] sig_fold(input logic [TD_W-1:0] d);
        logic [CHUNKS*32-1:0] padded;
        logic [31:0]          f;
        padded         = '0;
        padded[TD_W-1:0] = d;
        f              = 32'd0;
        for (int i = 0; i < CHUNKS; i++) begin
            f = f ^ padded[i*32 +: 32];
        end
        return f;
    endfunction

    logic [1:0]              state_r;
    logic [LOGS_FFT_LEN-1:0] beat_cnt_r;
    logic [IDLE_W-1:0]       idle_cnt_r;
    logic [31:0]             sig_r;
    logic [31:0]             hist0_r;
    logic [31:0]             hist1_r;
    logic [FRM_W-1:0]        frm_cnt_r;
    logic                    finished_r;
    logic                    pass_r;
    logic                    err_len_r;
    logic                    err_sig_r;
    logic                    err_timeout_r;

    logic [31:0]             sig_base_s;
    logic [31:0]             sig_next_s;
    logic                    last_beat_s;
    logic                    new_len_s;
    logic                    new_sig_s;
    logic                    frm_done_s;
    logic                    idle_expire_s;

    // Running signature and per-beat error/termination decisions.
    always_comb begin
        sig_base_s    = 32'd0;
        if (beat_cnt_r == '0) begin
            sig_base_s = 32'd0;
        end else begin
            sig_base_s = sig_r;
        end
        sig_next_s    = {sig_base_s[30:0], sig_base_s[31]} ^ sig_fold(i_axi4s_data_tdata);
        last_beat_s   = (beat_cnt_r == {LOGS_FFT_LEN{1'b1}});
        new_len_s     = ~last_beat_s;
        new_sig_s     = (frm_cnt_r >= FRM_W'(2)) && (sig_next_s != hist1_r);
        frm_done_s    = ((frm_cnt_r + FRM_W'(1)) == FRM_W'(TEST_FRAME_NUM));
        idle_expire_s = (idle_cnt_r == IDLE_W'(TIMEOUT_CYC - 1));
    end

    // Check-run FSM, counters, signature history and sticky flags.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state_r       <= ST_IDLE;
            beat_cnt_r    <= '0;
            idle_cnt_r    <= '0;
            sig_r         <= 32'd0;
            hist0_r       <= 32'd0;
            hist1_r       <= 32'd0;
            frm_cnt_r     <= '0;
            finished_r    <= 1'b0;
            pass_r        <= 1'b0;
            err_len_r     <= 1'b0;
            err_sig_r     <= 1'b0;
            err_timeout_r <= 1'b0;
        end else if (i_aclken) begin
            finished_r <= 1'b0;
            if (i_start_test) begin
                state_r       <= ST_RUN;
                beat_cnt_r    <= '0;
                idle_cnt_r    <= '0;
                sig_r         <= 32'd0;
                hist0_r       <= 32'd0;
                hist1_r       <= 32'd0;
                frm_cnt_r     <= '0;
                pass_r        <= 1'b0;
                err_len_r     <= 1'b0;
                err_sig_r     <= 1'b0;
                err_timeout_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_RUN: begin
                        if (i_axi4s_data_tvalid) begin
                            idle_cnt_r <= '0;
                            if (i_axi4s_data_tlast) begin
                                beat_cnt_r <= '0;
                                sig_r      <= 32'd0;
                                hist1_r    <= hist0_r;
                                hist0_r    <= sig_next_s;
                                frm_cnt_r  <= frm_cnt_r + FRM_W'(1);
                                if (new_len_s) begin
                                    err_len_r <= 1'b1;
                                end else begin
                                    err_len_r <= err_len_r;
                                end
                                if (new_sig_s) begin
                                    err_sig_r <= 1'b1;
                                end else begin
                                    err_sig_r <= err_sig_r;
                                end
                                if (frm_done_s) begin
                                    state_r    <= ST_DONE;
                                    finished_r <= 1'b1;
                                    pass_r     <= ~(err_len_r | err_sig_r | err_timeout_r
                                                    | new_len_s | new_sig_s);
                                end else begin
                                    state_r    <= ST_RUN;
                                end
                            end else if (last_beat_s) begin
                                // Overlong frame: flag it and resynchronise without counting it.
                                err_len_r  <= 1'b1;
                                beat_cnt_r <= '0;
                                sig_r      <= 32'd0;
                            end else begin
                                beat_cnt_r <= beat_cnt_r + LOGS_FFT_LEN'(1);
                                sig_r      <= sig_next_s;
                            end
                        end else if (idle_expire_s) begin
                            err_timeout_r <= 1'b1;
                            state_r       <= ST_DONE;
                            finished_r    <= 1'b1;
                            pass_r        <= 1'b0;
                            idle_cnt_r    <= '0;
                        end else begin
                            idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
                        end
                    end
                    ST_IDLE: state_r <= ST_IDLE;
                    ST_DONE: state_r <= ST_DONE;
                    default: state_r <= ST_IDLE;
                endcase
            end
        end else begin
            finished_r <= finished_r;
        end
    end

    assign o_chk_finished = finished_r;
    assign o_test_pass    = pass_r;
    assign o_err_len      = err_len_r;
    assign o_err_sig      = err_sig_r;
    assign o_err_timeout  = err_timeout_r;
    assign o_frm_cnt      = frm_cnt_r;

endmodule

// File: tb/tb_ipsxb_fft_result_chk.sv
// Directed bench for ipsxb_fft_result_chk: table of whole-run scenarios plus
// hand-written timeout, restart and reset sequences.
module tb_ipsxb_fft_result_chk;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          i_areset;
    logic          i_aclken;
    logic          i_start_test;
    logic          tvalid;
    logic [2*DW-1:0] tdata;
    logic          tlast;
    logic          o_chk_finished;
    logic          o_test_pass;
    logic          o_err_len;
    logic          o_err_sig;
    logic          o_err_timeout;
    logic [3:0]    o_frm_cnt;

    int  checks = 0;
    int  errors = 0;
    int  fin_cnt = 0;
    bit  toggle_en = 1'b0;
    bit  en_ph = 1'b1;

    always #5 clk = ~clk;

    ipsxb_fft_result_chk dut (
        .i_aclk              (clk),
        .i_areset            (i_areset),
        .i_aclken            (i_aclken),
        .i_start_test        (i_start_test),
        .i_axi4s_data_tvalid (tvalid),
        .i_axi4s_data_tdata  (tdata),
        .i_axi4s_data_tlast  (tlast),
        .o_chk_finished      (o_chk_finished),
        .o_test_pass         (o_test_pass),
        .o_err_len           (o_err_len),
        .o_err_sig           (o_err_sig),
        .o_err_timeout       (o_err_timeout),
        .o_frm_cnt           (o_frm_cnt)
    );

    // A finished pulse is consumed by the enabled edge that follows it.
    always @(negedge clk) begin
        if (i_aclken && o_chk_finished) fin_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Apply inputs and advance until one enabled edge has consumed them.
    task automatic cyc(input logic v, input logic [2*DW-1:0] d, input logic l);
        tvalid = v;
        tdata  = d;
        tlast  = l;
        do begin
            if (toggle_en) en_ph = ~en_ph;
            else en_ph = 1'b1;
            i_aclken = en_ph;
            @(posedge clk);
            #1;
        end while (!en_ph);
    endtask

    function automatic logic [2*DW-1:0] fdata(input int par, input int b);
        if (par == 0) return 48'h000001_000002;
        else return {24'(b * 5 + 3), 24'hFFFFF0 - 24'(b)};
    endfunction

    task automatic send_frame(input int par, input int len, input int tl_pos, input int flip);
        logic [2*DW-1:0] d;
        for (int b = 0; b < len; b++) begin
            d = fdata(par, b);
            if (b == flip) d[0] = ~d[0];
            cyc(1'b1, d, (b == tl_pos));
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic start(input logic with_beat);
        i_start_test = 1'b1;
        cyc(with_beat, fdata(0, 0), 1'b0);
        i_start_test = 1'b0;
        tvalid       = 1'b0;
        fin_cnt      = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
    endtask

    typedef struct {
        logic [63:0] name;
        bit          toggle;
        int          short_frm;
        int          miss_frm;
        int          flip_frm;
        int          frames_sent;
        int          e_frm;
        bit          e_pass;
        bit          e_len;
        bit          e_sig;
        bit          chk_sig;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{"nominal",  1'b0, -1, -1, -1, 10, 10, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{"short",    1'b0,  3, -1, -1, 10, 10, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"misslast", 1'b0, -1,  2, -1, 11, 10, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{"corrupt",  1'b0, -1, -1,  4, 10, 10, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{"clken",    1'b1, -1, -1, -1, 10, 10, 1'b1, 1'b0, 1'b0, 1'b1};

        i_areset = 1'b1; i_aclken = 1'b1; i_start_test = 1'b0;
        tvalid = 1'b0; tdata = '0; tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_areset = 1'b0;
        chk("reset_outputs", {o_chk_finished, o_test_pass, o_err_len, o_err_sig,
                              o_err_timeout, o_frm_cnt}, 0);
        send_frame(0, 16, 15, -1);
        chk("idle_ignores_beats", o_frm_cnt, 0);

        for (int v = 0; v < 5; v++) begin
            int par_idx;
            toggle_en = vecs[v].toggle;
            start(1'b0);
            par_idx = 0;
            for (int g = 0; g < vecs[v].frames_sent; g++) begin
                if (g == vecs[v].frames_sent - 1) begin
                    chk($sformatf("%0s_pre_frm", vecs[v].name), o_frm_cnt, vecs[v].e_frm - 1);
                    chk($sformatf("%0s_pre_fin", vecs[v].name), fin_cnt, 0);
                end
                if (g == vecs[v].miss_frm) begin
                    send_frame(par_idx % 2, 16, -1, -1);
                end else if (g == vecs[v].short_frm) begin
                    send_frame(par_idx % 2, 14, 13, -1);
                    par_idx++;
                end else begin
                    send_frame(par_idx % 2, 16, 15, (g == vecs[v].flip_frm) ? 5 : -1);
                    par_idx++;
                end
            end
            idle(5);
            chk($sformatf("%0s_frm", vecs[v].name), o_frm_cnt, vecs[v].e_frm);
            chk($sformatf("%0s_fin", vecs[v].name), fin_cnt, 1);
            chk($sformatf("%0s_pass", vecs[v].name), o_test_pass, vecs[v].e_pass);
            chk($sformatf("%0s_len", vecs[v].name), o_err_len, vecs[v].e_len);
            if (vecs[v].chk_sig)
                chk($sformatf("%0s_sig", vecs[v].name), o_err_sig, vecs[v].e_sig);
            chk($sformatf("%0s_tmo", vecs[v].name), o_err_timeout, 0);
        end
        toggle_en = 1'b0;

        // Stall: timeout exactly on the 4096th idle enabled cycle.
        start(1'b0);
        for (int g = 0; g < 4; g++) send_frame(g % 2, 16, 15, -1);
        idle(4095);
        chk("stall_tmo_early", o_err_timeout, 0);
        chk("stall_fin_early", o_chk_finished, 0);
        idle(1);
        chk("stall_tmo", o_err_timeout, 1);
        chk("stall_fin_pulse", o_chk_finished, 1);
        chk("stall_pass", o_test_pass, 0);
        chk("stall_frm", o_frm_cnt, 4);
        idle(1);
        chk("stall_fin_once", fin_cnt, 1);
        chk("stall_fin_low", o_chk_finished, 0);
        chk("stall_tmo_hold", o_err_timeout, 1);

        // Restart mid-run, with a beat coincident with the start pulse.
        start(1'b0);
        for (int g = 0; g < 5; g++) send_frame(g % 2, 16, 15, -1);
        send_frame(1, 7, -1, -1);
        start(1'b1);
        chk("restart_frm", o_frm_cnt, 0);
        chk("restart_len", o_err_len, 0);
        for (int g = 0; g < 10; g++) send_frame(g % 2, 16, 15, -1);
        idle(3);
        chk("restart_frm_end", o_frm_cnt, 10);
        chk("restart_pass", o_test_pass, 1);
        chk("restart_fin", fin_cnt, 1);
        chk("restart_errs", {o_err_len, o_err_sig, o_err_timeout}, 0);

        // Asynchronous reset mid-frame.
        start(1'b0);
        send_frame(0, 14, 13, -1);
        chk("pre_rst_len", o_err_len, 1);
        chk("pre_rst_frm", o_frm_cnt, 1);
        send_frame(1, 5, -1, -1);
        #2 i_areset = 1'b1;
        #1;
        chk("async_rst_outputs", {o_chk_finished, o_test_pass, o_err_len, o_err_sig,
                                  o_err_timeout, o_frm_cnt}, 0);
        @(posedge clk);
        #1 i_areset = 1'b0;
        send_frame(0, 16, 15, -1);
        chk("post_rst_idle_frm", o_frm_cnt, 0);
        chk("post_rst_idle_len", o_err_len, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
